// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, write-FSM encoding and bit-reversal helper for the FFT front end
//
// Purpose: default frame geometry, write-side state encoding and the
// bitrev() index helper used by fft_bitrev_buffer.
// Ports: none (package).

package fft_pkg;

  localparam int DATA_WIDTH_DEFAULT  = 16;
  localparam int FFT_POINTS_DEFAULT  = 64;
  localparam int LOG2_POINTS_DEFAULT = 6;

  typedef enum logic {
    W_FILL = 1'b0,
    W_PAD  = 1'b1
  } wr_state_t;

  // Reverse the low 'width' bits of idx; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[i] = idx[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// rtl/fft_bitrev_bank.sv - two-bank sample store with one write port and one combinational read port
//
// Purpose: holds two complete frames of packed {real, imag} words.
//          Address is {bank, idx}; the bank bit is the MSB.
// Ports:
//   clk      in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   {bank, idx} write address
//   wr_data  in   packed {real, imag} word
//   rd_addr  in   {bank, idx} read address
//   rd_data  out  word at rd_addr, combinational

module fft_bitrev_bank
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int LOG2_POINTS = LOG2_POINTS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [LOG2_POINTS:0]      wr_addr,
  input  logic [2*DATA_WIDTH-1:0]   wr_data,
  input  logic [LOG2_POINTS:0]      rd_addr,
  output logic [2*DATA_WIDTH-1:0]   rd_data
);

  localparam int DEPTH = 2 ** (LOG2_POINTS + 1);

  // No reset: bank contents are only ever trusted once the owning full flag is set.
  logic [2*DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// rtl/fft_bitrev_buffer.sv - ping-pong frame buffer replaying samples in bit-reversed order
//
// Purpose: collects a frame of complex samples, zero-pads short frames to
//          FFT_POINTS and replays each frame in bit-reversed order while the
//          next frame fills the other bank.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake
//   in_real/in_imag        input sample (signed)
//   in_last                final sample of an input frame
//   out_valid/out_ready    output handshake
//   out_real/out_imag      output sample, bit-reversed order
//   out_index              natural-order index of the output sample
//   out_last               final sample of an output frame
//   frame_err              one-cycle pulse on a frame length other than FFT_POINTS

module fft_bitrev_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int FFT_POINTS  = FFT_POINTS_DEFAULT,
  parameter int LOG2_POINTS = LOG2_POINTS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_real,
  input  logic signed [DATA_WIDTH-1:0]  in_imag,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_real,
  output logic signed [DATA_WIDTH-1:0]  out_imag,
  output logic [LOG2_POINTS-1:0]        out_index,
  output logic                          out_last,
  output logic                          frame_err
);

  localparam logic [LOG2_POINTS-1:0] LAST_IDX = LOG2_POINTS'(FFT_POINTS - 1);

  wr_state_t               wr_state;
  logic                    wr_bank;
  logic                    rd_bank;
  logic [1:0]              full;
  logic [1:0]              full_next;
  logic [LOG2_POINTS-1:0]  wr_cnt;
  logic [LOG2_POINTS-1:0]  rd_cnt;

  logic                    accept;
  logic                    wr_en;
  logic                    seal;
  logic                    load;
  logic                    release_bank;
  logic [LOG2_POINTS-1:0]  wr_idx_rev;
  logic [LOG2_POINTS-1:0]  rd_idx_rev;
  logic [LOG2_POINTS:0]    wr_addr;
  logic [LOG2_POINTS:0]    rd_addr;
  logic [2*DATA_WIDTH-1:0] wr_data;
  logic [2*DATA_WIDTH-1:0] rd_data;

  // ---------------- write side ----------------
  assign in_ready   = !rst && (wr_state == W_FILL) && !full[wr_bank];
  assign accept     = in_valid && in_ready;
  // Padding writes one zero per cycle without any input handshake.
  assign wr_en      = accept || (wr_state == W_PAD);
  assign seal       = wr_en && (wr_cnt == LAST_IDX);
  assign wr_data    = (wr_state == W_PAD) ? '0 : {in_real, in_imag};
  assign wr_idx_rev = LOG2_POINTS'(bitrev(32'(wr_cnt), LOG2_POINTS));
  assign wr_addr    = {wr_bank, wr_idx_rev};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_FILL;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (wr_en) begin
        if (seal) begin
          wr_cnt   <= '0;
          wr_bank  <= ~wr_bank;
          wr_state <= W_FILL;
          // A full-length frame without in_last is too long; the next sample opens a new frame.
          if (wr_state == W_FILL && !in_last) begin
            frame_err <= 1'b1;
          end
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
          if (wr_state == W_FILL && in_last) begin
            frame_err <= 1'b1;
            wr_state  <= W_PAD;
          end
        end
      end
    end
  end

  // ---------------- bank ownership ----------------
  // The sealing bank and the releasing bank always differ, so both updates apply.
  always_comb begin
    full_next = full;
    if (seal) begin
      full_next[wr_bank] = 1'b1;
    end
    if (release_bank) begin
      full_next[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      full <= full_next;
    end
  end

  // ---------------- storage ----------------
  fft_bitrev_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LOG2_POINTS (LOG2_POINTS)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- read side ----------------
  // Samples were stored at bitrev(k), so reading sequentially yields bit-reversed order.
  assign load         = full[rd_bank] && (!out_valid || out_ready);
  assign release_bank = load && (rd_cnt == LAST_IDX);
  assign rd_addr      = {rd_bank, rd_cnt};
  assign rd_idx_rev   = LOG2_POINTS'(bitrev(32'(rd_cnt), LOG2_POINTS));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
    end else if (load) begin
      out_valid              <= 1'b1;
      {out_real, out_imag}   <= rd_data;
      out_index              <= rd_idx_rev;
      out_last               <= (rd_cnt == LAST_IDX);
      // The bank is handed back as soon as its last word is in the output register.
      if (release_bank) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// tb/tb_fft_bitrev_buffer.sv - self-checking bench for fft_bitrev_buffer against a frame-level model

module tb_fft_bitrev_buffer;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int LG = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [DW-1:0]  in_real = '0;
  logic signed [DW-1:0]  in_imag = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic signed [DW-1:0]  out_real;
  logic signed [DW-1:0]  out_imag;
  logic [LG-1:0]         out_index;
  logic                  out_last;
  logic                  frame_err;

  always #5 clk = ~clk;

  fft_bitrev_buffer #(
    .DATA_WIDTH  (DW),
    .FFT_POINTS  (N),
    .LOG2_POINTS (LG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    bit            last;
  } smp_t;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
    bit            last;
    bit            first;
  } exp_t;

  smp_t src_q[$];
  smp_t cur_frame[$];
  exp_t exp_q[$];
  int   first_cycs[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  bit err_exp = 1'b0;

  int n_acc, n_take, n_rdy_low, n_err;
  int last_acc_cyc, first_valid_cyc, first_take_cyc, last_take_cyc;

  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < LG; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A frame closes on in_last or on reaching N samples; the output is the
  // zero-padded frame read at natural index rev(r) for r = 0..N-1.
  task automatic model_accept(input smp_t s);
    exp_t e;
    int   k;
    cur_frame.push_back(s);
    if (s.last || cur_frame.size() == N) begin
      err_exp = (cur_frame.size() != N) || !s.last;
      for (int r = 0; r < N; r++) begin
        k       = rev(r);
        e.re    = (k < cur_frame.size()) ? cur_frame[k].re : '0;
        e.im    = (k < cur_frame.size()) ? cur_frame[k].im : '0;
        e.idx   = k;
        e.last  = (r == N - 1);
        e.first = (r == 0);
        exp_q.push_back(e);
      end
      cur_frame.delete();
    end
  endtask

  task automatic push_frame(input int len, input int last_pos, input bit ramp);
    smp_t s;
    for (int k = 0; k < len; k++) begin
      s.re   = ramp ? DW'(k)  : DW'($urandom);
      s.im   = ramp ? DW'(-k) : DW'($urandom);
      s.last = (k == last_pos);
      src_q.push_back(s);
    end
  endtask

  // rmode: 0 out_ready low, 1 high, 2 random. vmode: 0 steady valid, 1 random gaps.
  // stop: 0 fixed cycles, 1 until everything drained, 2 until the source is empty.
  task automatic run(input int max_cyc, input int rmode, input int vmode, input int stop);
    exp_t e;
    n_acc = 0; n_take = 0; n_rdy_low = 0; n_err = 0;
    last_acc_cyc = -1; first_valid_cyc = -1; first_take_cyc = -1; last_take_cyc = -1;
    first_cycs.delete();
    for (int i = 0; i < max_cyc; i++) begin
      if (stop == 1 && src_q.size() == 0 && exp_q.size() == 0 && cur_frame.size() == 0) break;
      if (stop == 2 && src_q.size() == 0) break;
      @(negedge clk);
      in_valid = (src_q.size() > 0) && (vmode == 0 || $urandom_range(3) != 0);
      if (src_q.size() > 0) begin
        in_real = src_q[0].re;
        in_imag = src_q[0].im;
        in_last = src_q[0].last;
      end else begin
        in_real = '0;
        in_imag = '0;
        in_last = 1'b0;
      end
      out_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : ($urandom_range(2) != 0);
      #1;
      cyc++;
      chk("frame_err", frame_err, err_exp);
      err_exp = 1'b0;
      if (frame_err) n_err++;
      if (!in_ready) n_rdy_low++;
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("out_data", {out_real, out_imag}, {e.re, e.im});
          chk("out_index", out_index, e.idx);
          chk("out_last", out_last, e.last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_take++;
            if (e.first) first_cycs.push_back(cyc);
            if (first_take_cyc < 0) first_take_cyc = cyc;
            last_take_cyc = cyc;
          end
        end
      end
      if (in_valid && in_ready) begin
        model_accept(src_q.pop_front());
        n_acc++;
        last_acc_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (stop == 1) chk("drain_timeout", src_q.size() + exp_q.size() + cur_frame.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("in_ready_during_rst", in_ready, 0);
    @(negedge clk);
    chk("out_valid_after_rst", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_out_data", {out_real, out_imag, out_index}, 0);
    src_q.delete();
    exp_q.delete();
    cur_frame.delete();
    err_exp = 1'b0;
  endtask

  initial begin
    do_reset();

    // Ramp frame with full-rate output.
    push_frame(N, N - 1, 1'b1);
    run(400, 1, 0, 1);
    chk("t1_taken", n_take, N);
    chk("t1_latency", first_valid_cyc - last_acc_cyc, 2);

    // Two back-to-back frames.
    push_frame(N, N - 1, 1'b0);
    push_frame(N, N - 1, 1'b0);
    run(600, 1, 0, 1);
    chk("t2_in_ready_drops", n_rdy_low, 0);
    chk("t2_frames", first_cycs.size(), 2);
    if (first_cycs.size() == 2) chk("t2_frame_spacing", first_cycs[1] - first_cycs[0], N);
    chk("t2_gapless", last_take_cyc - first_take_cyc, 2 * N - 1);

    // Both banks full under backpressure, then release.
    push_frame(N, N - 1, 1'b0);
    push_frame(N, N - 1, 1'b0);
    push_frame(N, N - 1, 1'b0);
    run(200, 0, 0, 0);
    chk("t3_accepted_stalled", n_acc, 2 * N);
    chk("t3_in_ready_stalled", in_ready, 0);
    run(1500, 1, 0, 1);
    chk("t3_third_frame_acc", n_acc, N);
    chk("t3_all_emitted", n_take, 3 * N);

    // Short frame, zero-padded.
    push_frame(40, 39, 1'b0);
    run(400, 1, 0, 1);
    chk("t4_pad_cycles", n_rdy_low, N - 40);
    chk("t4_err_pulses", n_err, 1);
    chk("t4_taken", n_take, N);

    // Over-length frame: sealed at N, remainder opens the next frame.
    push_frame(N, -1, 1'b0);
    push_frame(10, 9, 1'b0);
    run(800, 1, 0, 1);
    chk("t5_err_pulses", n_err, 2);
    chk("t5_taken", n_take, 2 * N);

    // Reset with frame 1 draining and frame 2 partly written.
    push_frame(N, N - 1, 1'b0);
    push_frame(30, -1, 1'b0);
    run(400, 1, 0, 2);
    chk("t6_draining", out_valid, 1);
    do_reset();
    run(20, 1, 0, 0);
    chk("t6_no_stale_valid", first_valid_cyc, -1);
    push_frame(N, N - 1, 1'b1);
    run(400, 1, 0, 1);
    chk("t6_taken", n_take, N);
    chk("t6_latency", first_valid_cyc - last_acc_cyc, 2);

    // Random lengths, random valid gaps and random backpressure.
    for (int i = 0; i < 400; i++) begin
      smp_t s;
      s.re   = DW'($urandom);
      s.im   = DW'($urandom);
      s.last = ($urandom_range(29) == 0) || (i == 399);
      src_q.push_back(s);
    end
    run(8000, 2, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
